psum_accum_ctrl: RTL and testbench
==================================

# psum_accum_ctrl

Read-modify-write controller for the MAC partial-sum buffer. It sits directly upstream of the true dual-port partial-sum RAM and drives both of its ports. It accumulates a stream of signed MAC products into addressed RAM entries at one product per cycle. On command it drains all entries in address order through a valid/ready output and zeroes each entry after it is read.

## Interface
Parameters:
- ADDR_WIDTH, 6: RAM address width.
- DATA_WIDTH, 16: partial-sum width; RAM word width.
- IN_WIDTH, 8: signed product width; must be ≤ DATA_WIDTH.
- DEPTH, 34: number of RAM entries used (addresses 0..DEPTH-1).

Ports:
- clk in 1: single clock; all logic is on the rising edge.
- rst_n in 1: reset, asynchronous and active-low.
- in_valid in 1: product valid.
- in_ready out 1: equals (state==ACC) && !drain_start; combinational.
- in_addr in ADDR_WIDTH: target entry, < DEPTH.
- in_data in IN_WIDTH: signed product.
- in_first in 1: when 1, overwrite the entry with the product instead of accumulating.
- drain_start in 1: one-cycle request to drain; sampled only in ACC.
- out_valid out 1, out_ready in 1: drain handshake.
- out_data out DATA_WIDTH, out_addr out ADDR_WIDTH, out_last out 1 (set when out_addr==DEPTH-1).
- busy out 1: high when state!=ACC or stage-1 is valid.
- ram_wea out 1, ram_addrA out ADDR_WIDTH, ram_dinA out DATA_WIDTH, ram_doutA in DATA_WIDTH: RAM port A. ram_wea is tied 0 and ram_dinA is tied 0.
- ram_web out 1, ram_addrB out ADDR_WIDTH, ram_dinB out DATA_WIDTH: RAM port B, used for writes only.

## Operation
The RAM has a 1-cycle registered read and no reset. Port A is used only for reads and port B only for writes.

States are ACC, DRAIN_RD, DRAIN_CAP and DRAIN_OUT. The reset state is ACC.

ACC:
- An accepted product drives ram_addrA=in_addr in the same cycle.
- The product's addr, sign-extended data and first flag are registered into stage-1.
- In the next cycle, stage-1 computes sum = first ? ext(data) : base + ext(data), where base is ram_doutA. It then writes sum via port B (ram_web=1, ram_addrB=addr, ram_dinB=sum).
- Forwarding: if the previous cycle wrote port B to the same address, base is the registered last-written value instead of ram_doutA. Only one-back forwarding is needed.

Transition ACC → DRAIN_RD:
- Taken on drain_start. No product is accepted in that cycle.
- The stage-1 write pending in that cycle completes at its end, so no extra flush state is needed.

Drain sequence, index k starting at 0:
- DRAIN_RD: ram_addrA=k; go to DRAIN_CAP.
- DRAIN_CAP: out_data<=ram_doutA and out_addr<=k. Write 0 to entry k via port B. Go to DRAIN_OUT.
- DRAIN_OUT: out_valid=1. out_data, out_addr and out_last hold stable until out_ready.
  - On handshake with k==DEPTH-1: go to ACC and reset k to 0.
  - Otherwise: k<=k+1 and go to DRAIN_RD.

Arithmetic: two's-complement addition, wrapping modulo 2^DATA_WIDTH (see Configuration).

Reset (at any time, including mid-drain or mid-accumulate):
- All outputs are 0: out_valid, out_data, out_addr, out_last, ram_web, ram_addrA, ram_addrB, ram_dinB.
- Stage-1 is invalidated, k=0 and state=ACC.
- RAM contents are not cleared. Software issues a drain, or uses in_first, before relying on them.

in_addr ≥ DEPTH: undefined; verification only asserts that it is never driven.

## Timing
- Accumulate throughput is 1 product per cycle with no bubbles, including back-to-back products to the same address.
- The RAM write for a product accepted at cycle t occurs at the end of cycle t+1.
- drain_start asserted at cycle c: first out_valid at c+3.
- Each subsequent entry takes out_ready-handshake + 2 cycles (3 cycles per entry minimum).
- out_valid never drops without a handshake.
- drain_start outside ACC is ignored.
- in_valid together with drain_start: the product is not accepted (in_ready=0) and must be held by upstream.

## Configuration
- PSUM_SAT_EN defined: accumulation saturates to +(2^(DATA_WIDTH-1)-1) and -2^(DATA_WIDTH-1) on signed overflow.
- PSUM_SAT_EN undefined: accumulation wraps modulo 2^DATA_WIDTH.
- The in_first overwrite path is identical in both cases.

## Test plan
- After reset, drain without prior writes: all outputs are 0 during reset and in_ready=1 after release. Each entry gets in_first=1 with data 0, then drain: 34 outputs, addr 0..33, all 0, out_last only on addr 33.
- Products 5, -3, 7 to addr 4 on consecutive cycles, the first with in_first=1, then drain: addr 4 = 9 and all other entries = 0. This exercises the forwarding hazard.
- Interleaved addr 1,2,1,2 with data 10,20,1,2 (first=1 on the first two), then drain: addr1=11, addr2=22. A second drain returns all zeros (clear-on-drain).
- Random out_ready backpressure during drain: data is stable while out_valid && !out_ready, and no entry is lost or duplicated.
- Overflow: addr 0 = 32767 (in_first), then +1. Without PSUM_SAT_EN the drain returns -32768; with PSUM_SAT_EN it returns 32767. Likewise -32768 + (-1) → 32767 / -32768.
- rst_n pulsed low during DRAIN_OUT at k=10: out_valid=0 immediately (asynchronous). After release, state=ACC, in_ready=1, and a new drain starts at addr 0.

Source files
------------

// File: rtl/psum_accum_ctrl_if.sv
// Handshake bundle for psum_accum_ctrl: product input, drain request, and drain output stream.
interface psum_accum_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [IN_WIDTH-1:0]   in_data;
    logic                  in_first;
    logic                  drain_start;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;
    logic                  busy;

    modport master (
        output in_valid, in_addr, in_data, in_first, drain_start, out_ready,
        input  in_ready, out_valid, out_data, out_addr, out_last, busy
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_first, drain_start, out_ready,
        output in_ready, out_valid, out_data, out_addr, out_last, busy
    );
endinterface

// File: rtl/psum_accum_ctrl.sv
// Read-modify-write partial-sum accumulator with clear-on-read drain over a dual-port RAM.
// Define PSUM_SAT_EN to saturate accumulation on signed overflow instead of wrapping.
module psum_accum_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 8,
    parameter int DEPTH      = 34
) (
    input  logic                  clk,
    input  logic                  rst_n,
    psum_accum_ctrl_if.slave      bus,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrA,
    output logic [DATA_WIDTH-1:0] ram_dinA,
    input  logic [DATA_WIDTH-1:0] ram_doutA,
    output logic                  ram_web,
    output logic [ADDR_WIDTH-1:0] ram_addrB,
    output logic [DATA_WIDTH-1:0] ram_dinB
);
    typedef enum logic [1:0] {ACC, DRAIN_RD, DRAIN_CAP, DRAIN_OUT} state_t;

    function automatic logic signed [DATA_WIDTH-1:0] acc_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] wide;
        wide = (DATA_WIDTH+1)'(a) + (DATA_WIDTH+1)'(b);
`ifdef PSUM_SAT_EN
        if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1])
            return wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
        return wide[DATA_WIDTH-1:0];
    endfunction

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        k_q, k_d;
    logic                         vld_p1_q, vld_p1_d;
    logic [ADDR_WIDTH-1:0]        addr_p1_q, addr_p1_d;
    logic signed [DATA_WIDTH-1:0] data_p1_q, data_p1_d;
    logic                         first_p1_q, first_p1_d;
    logic                         last_we_q, last_we_d;
    logic [ADDR_WIDTH-1:0]        last_addr_q, last_addr_d;
    logic signed [DATA_WIDTH-1:0] last_data_q, last_data_d;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0]        out_addr_q, out_addr_d;
    logic                         out_last_q, out_last_d;

    logic                         accept;
    logic                         k_is_last;
    logic signed [DATA_WIDTH-1:0] ext_in;
    logic signed [DATA_WIDTH-1:0] base_p1;
    logic signed [DATA_WIDTH-1:0] sum_p1;

    assign bus.in_ready  = (state_q == ACC) && !bus.drain_start;
    assign accept        = bus.in_valid && bus.in_ready;
    assign k_is_last     = (k_q == ADDR_WIDTH'(DEPTH - 1));
    assign ext_in        = DATA_WIDTH'(signed'(bus.in_data));
    assign bus.out_valid = (state_q == DRAIN_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != ACC) || vld_p1_q;
    assign ram_wea       = 1'b0;
    assign ram_dinA      = '0;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            ACC:       if (bus.drain_start) state_d = DRAIN_RD;
            DRAIN_RD:  state_d = DRAIN_CAP;
            DRAIN_CAP: state_d = DRAIN_OUT;
            DRAIN_OUT: begin
                if (bus.out_ready) begin
                    if (k_is_last) begin
                        state_d = ACC;
                        k_d     = '0;
                    end else begin
                        state_d = DRAIN_RD;
                        k_d     = k_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default:   state_d = ACC;
        endcase
    end

    // The RAM read lands one cycle late, so a write made last cycle to the same
    // entry is not yet visible on ram_doutA and must be forwarded.
    always_comb begin
        vld_p1_d   = accept;
        addr_p1_d  = bus.in_addr;
        data_p1_d  = ext_in;
        first_p1_d = bus.in_first;
        base_p1    = (last_we_q && (last_addr_q == addr_p1_q)) ? last_data_q
                                                                : ram_doutA;
        sum_p1     = first_p1_q ? data_p1_q : acc_add(base_p1, data_p1_q);

        ram_addrA = '0;
        if (accept)
            ram_addrA = bus.in_addr;
        else if (state_q == DRAIN_RD)
            ram_addrA = k_q;

        ram_web   = 1'b0;
        ram_addrB = '0;
        ram_dinB  = '0;
        if (vld_p1_q) begin
            ram_web   = 1'b1;
            ram_addrB = addr_p1_q;
            ram_dinB  = sum_p1;
        end else if (state_q == DRAIN_CAP) begin
            ram_web   = 1'b1;
            ram_addrB = k_q;
        end

        last_we_d   = ram_web;
        last_addr_d = ram_addrB;
        last_data_d = ram_dinB;

        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        out_last_d = out_last_q;
        if (state_q == DRAIN_CAP) begin
            out_data_d = ram_doutA;
            out_addr_d = k_q;
            out_last_d = k_is_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            k_q        <= '0;
            vld_p1_q   <= 1'b0;
            last_we_q  <= 1'b0;
            out_data_q <= '0;
            out_addr_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            vld_p1_q   <= vld_p1_d;
            last_we_q  <= last_we_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
            out_last_q <= out_last_d;
        end
    end

    // Stage-1 payload and forwarding data are only consumed under their valid flags.
    always_ff @(posedge clk) begin
        addr_p1_q   <= addr_p1_d;
        data_p1_q   <= data_p1_d;
        first_p1_q  <= first_p1_d;
        last_addr_q <= last_addr_d;
        last_data_q <= last_data_d;
    end
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed-plus-random bench for psum_accum_ctrl against an array-based model of the partial-sum buffer.
module tb_psum_accum_ctrl;
    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int IW    = 8;
    localparam int DEPTH = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psum_accum_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_WIDTH(IW)) bus ();

    logic          ram_wea, ram_web;
    logic [AW-1:0] ram_addrA, ram_addrB;
    logic [DW-1:0] ram_dinA, ram_doutA, ram_dinB;
    logic [DW-1:0] mem [2**AW];

    always @(posedge clk) begin
        ram_doutA <= mem[ram_addrA];
        if (ram_web) mem[ram_addrB] <= ram_dinB;
    end

    psum_accum_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ram_wea(ram_wea), .ram_addrA(ram_addrA), .ram_dinA(ram_dinA), .ram_doutA(ram_doutA),
        .ram_web(ram_web), .ram_addrB(ram_addrB), .ram_dinB(ram_dinB)
    );

    int total = 0;
    int bad   = 0;
    int model [DEPTH];
    int got   [DEPTH];

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_add(input int a, input int b);
        int s;
        s = a + b;
`ifdef PSUM_SAT_EN
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
`else
        return int'($signed(s[15:0]));
`endif
    endfunction

    // Called at a falling edge; the product is taken on the following rising edge.
    task automatic push(input int a, input int d, input bit f);
        bus.in_valid = 1'b1;
        bus.in_addr  = AW'(a);
        bus.in_data  = IW'(d);
        bus.in_first = f;
        @(negedge clk);
        model[a] = f ? d : ref_add(model[a], d);
        bus.in_valid = 1'b0;
    endtask

    // Drains the buffer; stop_at >= 0 returns while entry stop_at is being offered.
    task automatic do_drain(input bit bp, input int stop_at);
        int  idx = 0, since = 0, idle = 0, hs_at = 0;
        bit  stall = 0;
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        bus.drain_start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr  = '0;
        bus.in_data  = IW'(99);
        bus.in_first = 1'b1;
        #1 chk("in_ready_at_drain_start", bus.in_ready, 0);
        @(negedge clk);
        bus.drain_start = 1'b0;
        bus.in_valid    = 1'b0;
        since = 1;
        chk("busy_in_drain", bus.busy, 1);
        while (idx < DEPTH) begin
            bus.out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (idx == stop_at) bus.out_ready = 1'b0;
            #1;
            if (bus.out_valid) begin
                idle = 0;
                if (idx == 0 && !stall) chk("first_valid_latency", since, 3);
                else if (!bp && !stall) chk("entry_gap", since - hs_at, 3);
                if (idx == stop_at) return;
                if (stall) begin
                    chk("stall_data_stable", bus.out_data, pd);
                    chk("stall_addr_stable", bus.out_addr, pa);
                end
                if (bus.out_ready) begin
                    chk("drain_addr", bus.out_addr, idx);
                    chk("drain_data", $signed(bus.out_data), model[idx]);
                    chk("drain_last", bus.out_last, (idx == DEPTH - 1));
                    got[idx]   = int'($signed(bus.out_data));
                    model[idx] = 0;
                    idx++;
                    hs_at = since;
                    stall = 0;
                end else begin
                    stall = 1;
                    pd = bus.out_data;
                    pa = bus.out_addr;
                end
            end else begin
                idle++;
                if (idle > 30) begin
                    chk("drain_timeout_idle", idle, 0);
                    break;
                end
            end
            @(negedge clk);
            since++;
        end
        bus.out_ready = 1'b0;
        chk("busy_after_drain", bus.busy, 0);
        chk("in_ready_after_drain", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_addr = '0; bus.in_data = '0; bus.in_first = 0;
        bus.drain_start = 0; bus.out_ready = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_addr", bus.out_addr, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_ram_web", ram_web, 0);
        chk("rst_ram_addrA", ram_addrA, 0);
        chk("rst_ram_addrB", ram_addrB, 0);
        chk("rst_ram_dinB", ram_dinB, 0);
        chk("rst_ram_wea", ram_wea, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", bus.in_ready, 1);
        chk("busy_after_reset", bus.busy, 0);

        // Initialise every entry with an overwrite of zero, then drain
        for (int a = 0; a < DEPTH; a++) push(a, 0, 1);
        do_drain(0, -1);

        // Back-to-back same-address products exercise forwarding
        push(4, 5, 1); push(4, -3, 0); push(4, 7, 0);
        do_drain(0, -1);
        chk("fwd_sum_addr4", got[4], 9);

        // Interleaved addresses, then clear-on-drain
        push(1, 10, 1); push(2, 20, 1); push(1, 1, 0); push(2, 2, 0);
        do_drain(0, -1);
        chk("interleave_addr1", got[1], 11);
        chk("interleave_addr2", got[2], 22);
        do_drain(1, -1);

        // Random products with gaps, then drain with backpressure
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            push(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)) - 128,
                 $urandom_range(0, 7) == 0);
        end
        do_drain(1, -1);

        // Overflow in both directions
        push(0, 127, 1);
        for (int n = 0; n < 257; n++) push(0, 127, 0);
        push(0, 1, 0); push(0, 1, 0);
        push(1, -128, 1);
        for (int n = 0; n < 255; n++) push(1, -128, 0);
        push(1, -1, 0);
        do_drain(1, -1);
`ifdef PSUM_SAT_EN
        chk("ovf_pos", got[0], 32767);
        chk("ovf_neg", got[1], -32768);
`else
        chk("ovf_pos", got[0], -32768);
        chk("ovf_neg", got[1], 32767);
`endif

        // Asynchronous reset while entry 10 is being offered
        for (int n = 0; n < 100; n++)
            push(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)) - 128,
                 $urandom_range(0, 5) == 0);
        do_drain(0, 10);
        chk("pre_reset_addr", bus.out_addr, 10);
        model[10] = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_out_data", bus.out_data, 0);
        chk("async_rst_out_addr", bus.out_addr, 0);
        chk("async_rst_ram_web", ram_web, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", bus.in_ready, 1);
        chk("post_reset_busy", bus.busy, 0);
        do_drain(1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
